// File: rtl/div_sched_if.sv
// div_sched_if: execute/decode/writeback bundle for the divide sequencer.
//   req_*      : divide request from execute (valid/ready handshake)
//   hold_o     : structural stall back to the pipeline
//   busy_o     : an operation is pending
//   id_reg*    : decode read addresses, raw_stall_o hazard back to decode
//   ex_reg_we_i: execute owns the GPR write port this cycle
//   wb_*       : divider GPR write port
// master = pipeline side, slave = div_sched.
interface div_sched_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic [1:0]      req_op_i;
    logic [XLEN-1:0] req_dividend_i;
    logic [XLEN-1:0] req_divisor_i;
    logic [4:0]      req_rd_i;
    logic            req_ready_o;
    logic            hold_o;
    logic            busy_o;
    logic [4:0]      id_reg1_raddr_i;
    logic [4:0]      id_reg2_raddr_i;
    logic            raw_stall_o;
    logic            ex_reg_we_i;
    logic            wb_we_o;
    logic [4:0]      wb_waddr_o;
    logic [XLEN-1:0] wb_wdata_o;

    modport master (
        output req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_rd_i,
        output id_reg1_raddr_i, id_reg2_raddr_i, ex_reg_we_i,
        input  req_ready_o, hold_o, busy_o, raw_stall_o,
        input  wb_we_o, wb_waddr_o, wb_wdata_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_rd_i,
        input  id_reg1_raddr_i, id_reg2_raddr_i, ex_reg_we_i,
        output req_ready_o, hold_o, busy_o, raw_stall_o,
        output wb_we_o, wb_waddr_o, wb_wdata_o
    );
endinterface

// File: rtl/div_sched.sv
// div_sched: sequencer for the iterative (1 bit/cycle) integer divide path.
// Accepts DIV/DIVU/REM/REMU from execute, runs restoring division, tracks
// the pending rd for RAW stalls and yields the GPR write port to execute.
// Ports:
//   clk  : core clock
//   rst  : synchronous reset, active-high
//   bus  : div_sched_if.slave (request, hazard and writeback signals)
// Optional build macro: DIV_EARLY_OUT_EN -- skip CALC when |dividend| <
// |divisor|; results are identical, only latency changes.
module div_sched #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    div_sched_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_CALC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;       // dividend, then quotient shift register in CALC
    logic [XLEN-1:0] b_q;       // divisor (magnitude once in CALC)
    logic [XLEN:0]   rem_q;     // one extra bit so the trial subtract cannot wrap
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic            neg_q, neg_r;

    // operand signs and magnitudes, valid while in CHECK
    logic            is_signed, a_neg, b_neg, ovf;
    logic [XLEN-1:0] abs_a, abs_b;
    assign is_signed = ~op_q[0];
    assign a_neg     = is_signed & a_q[XLEN-1];
    assign b_neg     = is_signed & b_q[XLEN-1];
    assign abs_a     = a_neg ? -a_q : a_q;
    assign abs_b     = b_neg ? -b_q : b_q;
    assign ovf       = is_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);

    // one restoring step: shift in next dividend bit, subtract if it fits
    logic [XLEN:0]   shifted, diff, rem_nxt;
    logic            take;
    logic [XLEN-1:0] quo_nxt, q_fix, r_fix;
    assign shifted = {rem_q[XLEN-1:0], a_q[XLEN-1]};
    assign diff    = shifted - {1'b0, b_q};
    assign take    = ~diff[XLEN];
    assign rem_nxt = take ? diff : shifted;
    assign quo_nxt = {a_q[XLEN-2:0], take};
    assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
    assign r_fix   = neg_r ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid_i) begin
                    op_q  <= bus.req_op_i;
                    a_q   <= bus.req_dividend_i;
                    b_q   <= bus.req_divisor_i;
                    rd_q  <= bus.req_rd_i;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (b_q == '0) begin
                        result_q <= op_q[1] ? a_q : '1;
                        state    <= S_DONE;
                    end else if (ovf) begin
                        result_q <= op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state    <= S_DONE;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs_a < abs_b) begin
                        // quotient is zero; remainder is the untouched dividend
                        result_q <= op_q[1] ? a_q : '0;
                        state    <= S_DONE;
                    end
`endif
                    else begin
                        a_q   <= abs_a;
                        b_q   <= abs_b;
                        rem_q <= '0;
                        cnt_q <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    a_q   <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        result_q <= op_q[1] ? r_fix : q_fix;
                        state    <= S_DONE;
                    end
                end
                default: begin
                    // rd==0 retires silently; otherwise wait for a free write port
                    if (rd_q == '0 || !bus.ex_reg_we_i) state <= S_IDLE;
                end
            endcase
        end
    end

    logic idle, wb_fire, rd_hit, acc_hit;
    assign idle    = (state == S_IDLE);
    assign wb_fire = (state == S_DONE) && (rd_q != '0) && !bus.ex_reg_we_i;
    assign rd_hit  = (rd_q != '0) &&
                     (bus.id_reg1_raddr_i == rd_q || bus.id_reg2_raddr_i == rd_q);
    assign acc_hit = bus.req_valid_i && (bus.req_rd_i != '0) &&
                     (bus.id_reg1_raddr_i == bus.req_rd_i ||
                      bus.id_reg2_raddr_i == bus.req_rd_i);

    assign bus.req_ready_o = idle;
    assign bus.hold_o      = bus.req_valid_i & ~idle;
    assign bus.busy_o      = ~idle;
    assign bus.raw_stall_o = idle ? acc_hit : rd_hit;
    assign bus.wb_we_o     = wb_fire;
    assign bus.wb_waddr_o  = wb_fire ? rd_q : '0;
    assign bus.wb_wdata_o  = wb_fire ? result_q : '0;
endmodule

// File: tb/tb_div_sched.sv
module tb_div_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_sched_if #(.XLEN(32)) bus();
    div_sched #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int NL = 34;
    localparam int SL = 2;
`ifdef DIV_EARLY_OUT_EN
    localparam int EL = 2;
`else
    localparam int EL = 34;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];
    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
        bus.req_op_i       = op;
        bus.req_dividend_i = a;
        bus.req_divisor_i  = b;
        bus.req_rd_i       = rd;
        bus.req_valid_i    = 1'b1;
        #1;
    endtask

    // accept, then watch for the strobe; latency counted in edges from accept
    task automatic run_vec(input vec_t v, input string nm);
        int c;
        logic [4:0]  wa;
        logic [31:0] wd;
        @(negedge clk);
        bus.ex_reg_we_i = 1'b0;
        drive_req(v.op, v.a, v.b, v.rd);
        chk({nm, "_ready"}, {31'd0, bus.req_ready_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        c = 1;
        while (!bus.wb_we_o && c < 100) begin
            @(negedge clk);
            c++;
        end
        wa = bus.wb_waddr_o;
        wd = bus.wb_wdata_o;
        chk({nm, "_lat"}, bus.wb_we_o ? c : 0, v.lat);
        chk({nm, "_waddr"}, {27'd0, wa}, {27'd0, v.rd});
        chk({nm, "_data"}, wd, v.exp);
        @(negedge clk);
        chk({nm, "_strobe_end"}, {30'd0, bus.wb_we_o, bus.busy_o}, 32'd0);
    endtask

    initial begin : main
        int c, bad, wbs;
        vecs[0]  = '{2'b01, 32'd100,       32'd7,         5'd5,  32'd14,        NL};
        vecs[1]  = '{2'b11, 32'd100,       32'd7,         5'd5,  32'd2,         NL};
        vecs[2]  = '{2'b00, 32'hFFFFFFF9,  32'd2,         5'd6,  32'hFFFFFFFD,  NL};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9,  32'd2,         5'd6,  32'hFFFFFFFF,  NL};
        vecs[4]  = '{2'b01, 32'hFFFFFFF9,  32'd2,         5'd7,  32'h7FFFFFFC,  NL};
        vecs[5]  = '{2'b00, 32'd123,       32'd0,         5'd8,  32'hFFFFFFFF,  SL};
        vecs[6]  = '{2'b11, 32'd123,       32'd0,         5'd8,  32'd123,       SL};
        vecs[7]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  5'd9,  32'h80000000,  SL};
        vecs[8]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  5'd9,  32'd0,         SL};
        vecs[9]  = '{2'b00, 32'hFFFFFFFB,  32'd3,         5'd11, 32'hFFFFFFFF,  NL};
        vecs[10] = '{2'b10, 32'hFFFFFFFB,  32'd3,         5'd11, 32'hFFFFFFFE,  NL};
        vecs[11] = '{2'b10, 32'd5,         32'hFFFFFFF8,  5'd12, 32'd5,         EL};
        vecs[12] = '{2'b00, 32'd20,        32'hFFFFFFFC,  5'd31, 32'hFFFFFFFB,  NL};
        vecs[13] = '{2'b01, 32'd5,         32'hFFFFFFF8,  5'd1,  32'd0,         EL};

        rst = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_dividend_i = '0;
        bus.req_divisor_i = '0; bus.req_rd_i = '0; bus.ex_reg_we_i = 1'b0;
        bus.id_reg1_raddr_i = '0; bus.id_reg2_raddr_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst_flags", {28'd0, bus.hold_o, bus.busy_o, bus.raw_stall_o, bus.wb_we_o}, 32'd0);
        chk("rst_waddr", {27'd0, bus.wb_waddr_o}, 32'd0);
        chk("rst_wdata", bus.wb_wdata_o, 32'd0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // RAW hazard on rs2 from accept through writeback, plus hold while busy
        @(negedge clk);
        bus.id_reg2_raddr_i = 5'd10;
        drive_req(2'b01, 32'd100, 32'd7, 5'd10);
        chk("raw_accept", {31'd0, bus.raw_stall_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bad = 0; c = 1;
        while (!bus.wb_we_o && c < 100) begin
            #1;
            if (!bus.raw_stall_o) bad++;
            if (c == 5) begin
                bus.req_valid_i = 1'b1;
                bus.req_rd_i = 5'd3;
                #1;
                chk("hold_busy", {30'd0, bus.hold_o, bus.req_ready_o}, 32'd2);
            end
            if (c == 6) bus.req_valid_i = 1'b0;
            @(negedge clk);
            c++;
        end
        chk("raw_during", bad, 0);
        chk("raw_wb_lat", bus.wb_we_o ? c : 0, NL);
        chk("raw_wb", {31'd0, bus.raw_stall_o}, 32'd1);
        @(negedge clk);
        chk("raw_after", {31'd0, bus.raw_stall_o}, 32'd0);
        bus.id_reg2_raddr_i = '0;

        // rd = 0: no hazard, no write
        @(negedge clk);
        drive_req(2'b01, 32'd9, 32'd3, 5'd0);
        bad = bus.raw_stall_o ? 1 : 0;
        wbs = 0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.raw_stall_o) bad++;
            if (bus.wb_we_o) wbs++;
            @(negedge clk);
        end
        chk("rd0_raw", bad, 0);
        chk("rd0_nowrite", wbs, 0);
        chk("rd0_idle", {31'd0, bus.busy_o}, 32'd0);

        // execute owns the write port for the first 3 DONE cycles
        @(negedge clk);
        drive_req(2'b01, 32'd100, 32'd7, 5'd7);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        c = 1; wbs = 0; bad = 0;
        while (c < 45) begin
            bus.ex_reg_we_i = (c >= 33 && c <= 36);
            #1;
            if (bus.wb_we_o) begin
                wbs++;
                if (bad == 0) bad = c;
                chk("exwait_waddr", {27'd0, bus.wb_waddr_o}, 32'd7);
                chk("exwait_data", bus.wb_wdata_o, 32'd14);
            end
            @(negedge clk);
            c++;
        end
        bus.ex_reg_we_i = 1'b0;
        chk("exwait_lat", bad, NL + 3);
        chk("exwait_single", wbs, 1);

        // reset in CALC iteration 15 abandons the op
        @(negedge clk);
        drive_req(2'b01, 32'd100, 32'd7, 5'd4);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("mrst_flags", {28'd0, bus.hold_o, bus.busy_o, bus.raw_stall_o, bus.wb_we_o}, 32'd0);
        chk("mrst_wb", {bus.wb_wdata_o[26:0], bus.wb_waddr_o}, 32'd0);
        wbs = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.wb_we_o) wbs++;
            @(negedge clk);
        end
        chk("mrst_nowrite", wbs, 0);
        run_vec('{2'b01, 32'd9, 32'd3, 5'd2, 32'd3, NL}, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Sequencing controller for the long-latency integer divide path.
- Decode issues DIV/DIVU/REM/REMU with the register write disabled. The execute stage hands the operation here, and this block runs a 1-bit/cycle iterative division.
- It tracks the pending destination register and raises a RAW stall to decode for that register.
- It arbitrates the single GPR write port against execute's normal writeback.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  1  execute presents a divide op
- req_op_i  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_dividend_i  in  XLEN  rs1 value
- req_divisor_i  in  XLEN  rs2 value
- req_rd_i  in  5  destination register
- req_ready_o  out  1  block idle, request accepted this cycle
- hold_o  out  1  structural stall to pipeline (req_valid_i & ~req_ready_o)
- busy_o  out  1  operation pending (state != IDLE)
- id_reg1_raddr_i  in  5  decode rs1 read address
- id_reg2_raddr_i  in  5  decode rs2 read address
- raw_stall_o  out  1  decode must hold: reads pending rd
- ex_reg_we_i  in  1  execute writes GPR this cycle (priority)
- wb_we_o  out  1  divider GPR write strobe
- wb_waddr_o  out  5  divider write address
- wb_wdata_o  out  XLEN  divider result

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; all internal registers 0.
  - Outputs: req_ready_o=1, hold_o=0, busy_o=0, raw_stall_o=0, wb_we_o=0, wb_waddr_o=0, wb_wdata_o=0.
  - Reset mid-operation abandons the operation; no write is issued.
- FSM: IDLE, CHECK, CALC, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch op, operands and rd, then go to CHECK.
- CHECK (1 cycle), special cases first:
  - divisor==0: quotient=all ones, remainder=dividend; go to DONE.
  - Signed op with dividend==0x80000000 and divisor==0xFFFFFFFF: quotient=0x80000000, remainder=0; go to DONE.
  - Otherwise: for signed ops take absolute values; record quotient-negate = sign(dividend)^sign(divisor) and remainder-negate = sign(dividend); clear the counter; go to CALC.
- CALC:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Partial remainder is XLEN+1 bits wide, so subtraction does not overflow.
  - Exactly XLEN cycles (counter 0..XLEN-1), then apply sign correction and go to DONE.
- DONE:
  - Result = quotient (DIV/DIVU) or remainder (REM/REMU).
  - If rd==0: return to IDLE next cycle, wb_we_o stays 0.
  - Else if ex_reg_we_i==1: wait in DONE, with no limit.
  - Else: wb_we_o=1, wb_waddr_o=rd, wb_wdata_o=result for exactly one cycle, then IDLE.
  - wb_* outputs are 0 whenever wb_we_o=0.
- Latency from the accept edge:
  - Normal: wb_we_o in cycle 1+XLEN+1 (cycle 34 for XLEN=32), plus any ex_reg_we_i wait cycles.
  - Special case: cycle 2.
- raw_stall_o:
  - Asserted when busy_o, rd!=0, and (id_reg1_raddr_i==rd or id_reg2_raddr_i==rd). This includes the writeback cycle.
  - Also asserted in the accept cycle (IDLE & req_valid_i) when req_rd_i!=0 and it matches either read address.
- A new request is accepted only in IDLE. There is no back-to-back accept in the writeback cycle; the next request is accepted in the following IDLE cycle.
- jump/flush inputs do not affect the block. A dispatched divide always completes.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in CHECK, if |dividend| < |divisor| (unsigned compare of the latched magnitudes, non-special case), go directly to DONE. Quotient=0, remainder=original dividend; latency 2.
- Undefined: the full XLEN-cycle CALC always runs. Results are identical either way; only latency differs.

Test Plan:
- DIVU 100/7, rd=5 → wb_we_o=1, waddr=5, wdata=14 at cycle 34 after accept. REMU with the same operands → 2.
- DIV 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIV 123/0 → 0xFFFFFFFF at cycle 2. REMU 123/0 → 123. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, both at cycle 2.
- Hazard and hold:
  - rd=10, id_reg2_raddr_i=10 → raw_stall_o=1 from the accept cycle through the writeback cycle, 0 after.
  - rd=0 → raw_stall_o never asserted, no write.
  - req_valid_i while busy → hold_o=1, req_ready_o=0.
- ex_reg_we_i=1 for 3 cycles on DONE entry → wb_we_o delayed exactly 3 cycles, data unchanged, single-cycle strobe.
- Reset at CALC iteration 15 → next cycle IDLE, all outputs reset values, no wb_we_o. A following DIVU 9/3 returns 3.
